input_buffer: RTL and testbench

- Host-side write buffer for the SHA-256 ASIC: the host writes sixteen 32-bit message words by address, then commits them.
- The block presents one 512-bit block to the compression core with a valid/ready handshake.
- It holds the block stable until the core signals completion.
- It is the input-direction counterpart to the addressed hash-word readback path.

---
 rtl/input_buffer.sv | 111 +++++++++++
 tb/tb_input_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// Host-side staging buffer: sixteen 32-bit words written by address, committed as one
// 512-bit block to the compression core and held stable until the core reports done.
//
// state | meaning
// FILL  | host writes accepted; commit with a full mask arms the block
// ARMED | block offered to the core (block_valid=1), waiting for core_ready
// RUN   | core owns the block; waiting for core_done
module input_buffer #(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   addr,
  input  logic [31:0]  in_var,
  input  logic         we,
  input  logic         commit,
  input  logic         core_ready,
  input  logic         core_done,
  output logic [511:0] block_out,
  output logic         block_valid,
  output logic         busy,
  output logic [15:0]  filled_mask,
  output logic         err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [31:0]  words_q [16];
  logic [31:0]  words_d [16];
  logic [15:0]  mask_q, mask_d;
  logic         err_q, err_d;

  logic [15:0]  mask_wr;
  logic [15:0]  mask_merged;
  logic         commit_ok;

  // A write landing in the same cycle as commit counts toward the full mask.
  always_comb begin
    mask_wr     = we ? (16'h0001 << addr) : 16'h0000;
    mask_merged = mask_q | mask_wr;
    commit_ok   = commit && (mask_merged == 16'hFFFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (commit_ok) state_d = ARMED;
      ARMED:   if (core_ready) state_d = RUN;
      RUN:     if (core_done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    block_valid = (state_q == ARMED);
    busy        = (state_q != FILL);
  end

  always_comb begin
    words_d = words_q;
    mask_d  = mask_q;
    err_d   = err_q;
    if (state_q == FILL) begin
      if (we) words_d[addr] = in_var;
      mask_d = mask_merged;
      if (commit) err_d = !commit_ok;
    end else begin
      if (we || commit) err_d = 1'b1;
      if ((state_q == RUN) && core_done) begin
        mask_d = 16'h0000;
        if (CLEAR_ON_DONE) begin
          for (int i = 0; i < 16; i++) words_d[i] = 32'h0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) words_q[i] <= 32'h0;
      mask_q <= 16'h0000;
      err_q  <= 1'b0;
    end else begin
      words_q <= words_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    block_out = '0;
    for (int i = 0; i < 16; i++) block_out[511-32*i -: 32] = words_q[i];
  end

  assign filled_mask = mask_q;
  assign err         = err_q;

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: a word-array reference model compared every
// cycle against two instances (CLEAR_ON_DONE=1 and 0), plus directed literal checks.
module tb_input_buffer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   addr = '0;
  logic [31:0]  in_var = '0;
  logic         we = 1'b0;
  logic         commit = 1'b0;
  logic         core_ready = 1'b0;
  logic         core_done = 1'b0;

  logic [511:0] block_out, block_out0;
  logic         block_valid, block_valid0;
  logic         busy, busy0;
  logic [15:0]  filled_mask, filled_mask0;
  logic         err, err0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  input_buffer #(.CLEAR_ON_DONE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .in_var(in_var), .we(we), .commit(commit),
    .core_ready(core_ready), .core_done(core_done), .block_out(block_out),
    .block_valid(block_valid), .busy(busy), .filled_mask(filled_mask), .err(err)
  );

  input_buffer #(.CLEAR_ON_DONE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .in_var(in_var), .we(we), .commit(commit),
    .core_ready(core_ready), .core_done(core_done), .block_out(block_out0),
    .block_valid(block_valid0), .busy(busy0), .filled_mask(filled_mask0), .err(err0)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = host filling, 1 = offered to core, 2 = core working.
  int          m_phase;
  logic [31:0] m_w1 [16];
  logic [31:0] m_w0 [16];
  logic [15:0] m_mask;
  logic        m_err;

  function automatic logic [511:0] pack(input logic [31:0] w [16]);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = (r << 32) | {480'h0, w[i]};
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_mask  = 16'h0;
      m_err   = 1'b0;
      for (int i = 0; i < 16; i++) begin
        m_w1[i] = 32'h0;
        m_w0[i] = 32'h0;
      end
    end else if (m_phase == 0) begin
      if (we) begin
        m_w1[addr] = in_var;
        m_w0[addr] = in_var;
        m_mask = m_mask | (16'h1 << addr);
      end
      if (commit) begin
        if (m_mask == 16'hFFFF) begin
          m_phase = 1;
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      if (we || commit) m_err = 1'b1;
      if (m_phase == 1) begin
        if (core_ready) m_phase = 2;
      end else if (core_done) begin
        m_phase = 0;
        m_mask = 16'h0;
        for (int i = 0; i < 16; i++) m_w1[i] = 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model block_out", block_out, pack(m_w1));
      chk("model block_out0", block_out0, pack(m_w0));
      chk("model block_valid", {block_valid0, block_valid}, {2{m_phase == 1}});
      chk("model busy", {busy0, busy}, {2{m_phase != 0}});
      chk("model filled_mask", {filled_mask0, filled_mask}, {2{m_mask}});
      chk("model err", {err0, err}, {2{m_err}});
    end
  end

  task automatic idle();
    we = 1'b0; commit = 1'b0; core_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; in_var = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  logic [511:0] held;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset block_out", block_out, 512'h0);
    chk("reset valid/busy/err", {block_valid, busy, err}, 3'b000);
    chk("reset mask", filled_mask, 16'h0);
    rst_n = 1'b1;
    idle();

    // core_done outside RUN is ignored
    wr(4'd0, 32'h11111111);
    pulse_done();
    chk("stray done mask", filled_mask, 16'h0001);
    chk("stray done err", err, 1'b0);

    // "abc" block with core_ready already high
    for (int i = 0; i < 16; i++)
      wr(i[3:0], (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0));
    chk("abc mask", filled_mask, 16'hFFFF);
    core_ready = 1'b1;
    do_commit();
    chk("abc valid", block_valid, 1'b1);
    chk("abc word0", block_out[511:480], 32'h61626380);
    chk("abc word15", block_out[31:0], 32'h00000018);
    idle();
    core_ready = 1'b0;
    chk("abc valid one cycle", {block_valid, busy}, 2'b01);
    idle();
    chk("abc busy in run", busy, 1'b1);
    pulse_done();
    chk("abc done mask", filled_mask, 16'h0);
    chk("abc done data cleared", block_out, 512'h0);
    chk("abc done busy", busy, 1'b0);
    chk("abc keep data word0", block_out0[511:480], 32'h61626380);
    chk("abc keep mask", filled_mask0, 16'h0);

    // Incomplete commit, then complete it
    for (int i = 0; i < 15; i++) wr(i[3:0], 32'(i + 1));
    do_commit();
    chk("incomplete err", err, 1'b1);
    chk("incomplete stays fill", {block_valid, busy}, 2'b00);
    chk("incomplete mask", filled_mask, 16'h7FFF);
    wr(4'd15, 32'h00000010);
    do_commit();
    chk("complete valid", block_valid, 1'b1);
    chk("complete err cleared", err, 1'b0);

    // Backpressure for 5 cycles
    held = block_out;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("bp valid held", block_valid, 1'b1);
      chk("bp block stable", block_out, held);
    end
    core_ready = 1'b1;
    idle();
    core_ready = 1'b0;
    chk("bp to run", {block_valid, busy}, 2'b01);

    // Write while busy is ignored and flags err
    wr(4'd3, 32'hDEADBEEF);
    chk("busy write word3", block_out[511-32*3 -: 32], 32'h00000004);
    chk("busy write err", err, 1'b1);
    pulse_done();
    wr(4'd3, 32'hDEADBEEF);
    chk("after done mask", filled_mask, 16'h0008);
    chk("after done word3", block_out[511-32*3 -: 32], 32'hDEADBEEF);
    chk("err sticky", err, 1'b1);

    // Same-cycle last write and commit
    for (int i = 0; i < 15; i++) if (i != 3) wr(i[3:0], 32'hA0 + 32'(i));
    we = 1'b1; addr = 4'd15; in_var = 32'h12345678; commit = 1'b1;
    @(negedge clk);
    we = 1'b0; commit = 1'b0;
    chk("same-cycle valid", block_valid, 1'b1);
    chk("same-cycle word15", block_out[31:0], 32'h12345678);
    chk("same-cycle err", err, 1'b0);

    // Asynchronous reset while ARMED
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid/busy", {block_valid, busy, block_valid0, busy0}, 4'b0000);
    chk("async rst mask", {filled_mask, filled_mask0}, 32'h0);
    chk("async rst data", block_out | block_out0, 512'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
